// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I memory stage.
// Holds the load/store funct3 encodings, the memory-stage FSM state type,
// the bit positions inside the CTRL_MEM / CTRL_WB bundles, and a helper
// that forms the word-aligned bus address.
package rv32i_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // CTRL_MEM = {memRead, memWrite}
    localparam int CM_READ  = 1;
    localparam int CM_WRITE = 0;

    // CTRL_WB = {regwrite, memtoReg}
    localparam int CW_REGWRITE = 1;
    localparam int CW_MEMTOREG = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational load/store lane alignment.
// Ports:
//   funct3     in  3   load/store width and signedness
//   is_store   in  1   1 = store lanes, 0 = load lanes
//   addr_lo    in  2   byte offset within the word
//   rs2        in  32  store data
//   rdata      in  32  word returned by the bus
//   be         out 4   byte enables
//   wdata      out 32  lane-replicated store data
//   load_data  out 32  extracted, extended load result
//   misalign   out 1   access crosses its natural alignment
module rv32i_lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;

    // Bring the addressed byte/half down to bit 0 before extension.
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be       = 4'b1111;
        wdata    = rs2;
        misalign = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{rs2[7:0]}};
                end
                F3_SH: begin
                    be       = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata    = {2{rs2[15:0]}};
                    misalign = addr_lo[0];
                end
                F3_SW: begin
                    misalign = (addr_lo != 2'b00);
                end
                default: ;
            endcase
        end else begin
            case (funct3)
                F3_LH, F3_LHU: misalign = addr_lo[0];
                F3_LW:         misalign = (addr_lo != 2'b00);
                default: ;
            endcase
        end
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_mem.sv
// RV32I MEM pipeline stage: issues data-memory requests, stalls the pipe
// while the bus is busy, and registers the MEM/WB bundle.
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   VALID_IN, CTRL_MEM_IN,
//   CTRL_WB_IN, ALURESULT_IN,
//   WRITEDATA_IN, INST_IN           EX/MEM slot
//   DMEM_REQ/WE/ADDR/WDATA/BE       bus request side
//   DMEM_READY/RDATA                bus response side
//   STALL_OUT                       hold EX/MEM upstream
//   VALID_OUT .. INST_OUT           registered MEM/WB bundle
//   MISALIGN_OUT, BUSERR_OUT        registered fault flags
//
// state | meaning
// IDLE  | accept a new slot; aligned memory ops are issued this cycle
// WAIT  | bus request outstanding, latched fields driven, counting timeout
module rv32i_mem
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VALID_IN,
    input  logic [1:0]  CTRL_MEM_IN,
    input  logic [1:0]  CTRL_WB_IN,
    input  logic [31:0] ALURESULT_IN,
    input  logic [31:0] WRITEDATA_IN,
    input  logic [31:0] INST_IN,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BE,
    input  logic        DMEM_READY,
    input  logic [31:0] DMEM_RDATA,
    output logic        STALL_OUT,
    output logic        VALID_OUT,
    output logic [1:0]  CTRL_WB_OUT,
    output logic [31:0] MEM_OUT,
    output logic [31:0] ALURESULT_OUT,
    output logic [31:0] INST_OUT,
    output logic        MISALIGN_OUT,
    output logic        BUSERR_OUT
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    mem_state_t  state;
    logic [15:0] wait_cnt;

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_we;
    logic        lat_load;
    logic [1:0]  lat_lo;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_ctrl_wb;
    logic [31:0] lat_alu;
    logic [31:0] lat_inst;

    logic        in_wait;
    logic        timeout;
    logic        is_mem;
    logic        is_store;
    logic        is_load;
    logic        issue;

    logic [2:0]  sel_f3;
    logic [1:0]  sel_lo;
    logic        sel_store;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misalign;

    assign in_wait  = (state == ST_WAIT);
    // The timeout cycle drops the request so STALL_OUT falls and the
    // faulted instruction leaves EX/MEM instead of being re-issued.
    assign timeout  = in_wait && (wait_cnt == TMO);
    assign is_mem   = VALID_IN & (CTRL_MEM_IN[CM_READ] | CTRL_MEM_IN[CM_WRITE]);
    assign is_store = CTRL_MEM_IN[CM_WRITE];
    assign is_load  = CTRL_MEM_IN[CM_READ] & ~CTRL_MEM_IN[CM_WRITE];
    assign issue    = ~in_wait & is_mem & ~al_misalign;

    // In WAIT the aligner works from the latched op so extraction does not
    // depend on upstream honouring the stall.
    assign sel_f3    = in_wait ? lat_f3 : INST_IN[14:12];
    assign sel_lo    = in_wait ? lat_lo : ALURESULT_IN[1:0];
    assign sel_store = in_wait ? lat_we : is_store;

    rv32i_lsu_align u_align (
        .funct3    (sel_f3),
        .is_store  (sel_store),
        .addr_lo   (sel_lo),
        .rs2       (WRITEDATA_IN),
        .rdata     (DMEM_RDATA),
        .be        (al_be),
        .wdata     (al_wdata),
        .load_data (al_load),
        .misalign  (al_misalign)
    );

    always_comb begin
        DMEM_REQ   = ~RST & (issue | (in_wait & ~timeout));
        DMEM_WE    = DMEM_REQ & (in_wait ? lat_we : is_store);
        DMEM_ADDR  = in_wait ? lat_addr  : word_addr(ALURESULT_IN);
        DMEM_WDATA = in_wait ? lat_wdata : al_wdata;
        DMEM_BE    = in_wait ? lat_be    : al_be;
        STALL_OUT  = DMEM_REQ & ~DMEM_READY;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            wait_cnt      <= 16'd0;
            lat_addr      <= 32'd0;
            lat_wdata     <= 32'd0;
            lat_be        <= 4'd0;
            lat_we        <= 1'b0;
            lat_load      <= 1'b0;
            lat_lo        <= 2'd0;
            lat_f3        <= 3'd0;
            lat_ctrl_wb   <= 2'd0;
            lat_alu       <= 32'd0;
            lat_inst      <= 32'd0;
            VALID_OUT     <= 1'b0;
            CTRL_WB_OUT   <= 2'b00;
            MEM_OUT       <= 32'd0;
            ALURESULT_OUT <= 32'd0;
            INST_OUT      <= 32'd0;
            MISALIGN_OUT  <= 1'b0;
            BUSERR_OUT    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_mem && al_misalign) begin
                        VALID_OUT     <= 1'b1;
                        CTRL_WB_OUT   <= 2'b00;
                        MEM_OUT       <= 32'd0;
                        ALURESULT_OUT <= ALURESULT_IN;
                        INST_OUT      <= INST_IN;
                        MISALIGN_OUT  <= 1'b1;
                        BUSERR_OUT    <= 1'b0;
                    end else if (is_mem) begin
                        lat_addr    <= word_addr(ALURESULT_IN);
                        lat_wdata   <= al_wdata;
                        lat_be      <= al_be;
                        lat_we      <= is_store;
                        lat_load    <= is_load;
                        lat_lo      <= ALURESULT_IN[1:0];
                        lat_f3      <= INST_IN[14:12];
                        lat_ctrl_wb <= CTRL_WB_IN;
                        lat_alu     <= ALURESULT_IN;
                        lat_inst    <= INST_IN;
                        MISALIGN_OUT <= 1'b0;
                        BUSERR_OUT   <= 1'b0;
                        if (DMEM_READY) begin
                            VALID_OUT     <= 1'b1;
                            CTRL_WB_OUT   <= CTRL_WB_IN;
                            MEM_OUT       <= is_load ? al_load : 32'd0;
                            ALURESULT_OUT <= ALURESULT_IN;
                            INST_OUT      <= INST_IN;
                        end else begin
                            state       <= ST_WAIT;
                            wait_cnt    <= 16'd0;
                            VALID_OUT   <= 1'b0;
                            CTRL_WB_OUT <= 2'b00;
                            MEM_OUT     <= 32'd0;
                        end
                    end else begin
                        VALID_OUT     <= VALID_IN;
                        CTRL_WB_OUT   <= CTRL_WB_IN;
                        MEM_OUT       <= 32'd0;
                        ALURESULT_OUT <= ALURESULT_IN;
                        INST_OUT      <= INST_IN;
                        MISALIGN_OUT  <= 1'b0;
                        BUSERR_OUT    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (timeout) begin
                        state         <= ST_IDLE;
                        VALID_OUT     <= 1'b1;
                        CTRL_WB_OUT   <= 2'b00;
                        MEM_OUT       <= 32'd0;
                        ALURESULT_OUT <= lat_alu;
                        INST_OUT      <= lat_inst;
                        MISALIGN_OUT  <= 1'b0;
                        BUSERR_OUT    <= 1'b1;
                    end else if (DMEM_READY) begin
                        state         <= ST_IDLE;
                        VALID_OUT     <= 1'b1;
                        CTRL_WB_OUT   <= lat_ctrl_wb;
                        MEM_OUT       <= lat_load ? al_load : 32'd0;
                        ALURESULT_OUT <= lat_alu;
                        INST_OUT      <= lat_inst;
                        MISALIGN_OUT  <= 1'b0;
                        BUSERR_OUT    <= 1'b0;
                    end else begin
                        wait_cnt    <= wait_cnt + 16'd1;
                        VALID_OUT   <= 1'b0;
                        CTRL_WB_OUT <= 2'b00;
                        MEM_OUT     <= 32'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem.sv
module tb_rv32i_mem;

    localparam int TMO = 4;
    localparam int NEVER = 1000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VALID_IN;
    logic [1:0]  CTRL_MEM_IN;
    logic [1:0]  CTRL_WB_IN;
    logic [31:0] ALURESULT_IN;
    logic [31:0] WRITEDATA_IN;
    logic [31:0] INST_IN;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_BE;
    logic        DMEM_READY;
    logic [31:0] DMEM_RDATA;
    logic        STALL_OUT;
    logic        VALID_OUT;
    logic [1:0]  CTRL_WB_OUT;
    logic [31:0] MEM_OUT;
    logic [31:0] ALURESULT_OUT;
    logic [31:0] INST_OUT;
    logic        MISALIGN_OUT;
    logic        BUSERR_OUT;

    rv32i_mem #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .VALID_IN(VALID_IN), .CTRL_MEM_IN(CTRL_MEM_IN), .CTRL_WB_IN(CTRL_WB_IN),
        .ALURESULT_IN(ALURESULT_IN), .WRITEDATA_IN(WRITEDATA_IN), .INST_IN(INST_IN),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE),
        .DMEM_READY(DMEM_READY), .DMEM_RDATA(DMEM_RDATA),
        .STALL_OUT(STALL_OUT),
        .VALID_OUT(VALID_OUT), .CTRL_WB_OUT(CTRL_WB_OUT), .MEM_OUT(MEM_OUT),
        .ALURESULT_OUT(ALURESULT_OUT), .INST_OUT(INST_OUT),
        .MISALIGN_OUT(MISALIGN_OUT), .BUSERR_OUT(BUSERR_OUT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected values for the current cycle (combinational) and for the
    // MEM/WB register as loaded at the most recent edge.
    logic        chk_en = 1'b0;
    logic        exp_req, exp_stall, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_valid, exp_mis, exp_bus;
    logic [1:0]  exp_ctrl;
    logic [31:0] exp_mem, exp_alu, exp_inst;
    logic        chk_valid, chk_data, chk_mem;

    int          stall_seen;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("dmem_req", 32'(DMEM_REQ), 32'(exp_req));
            chk("stall_out", 32'(STALL_OUT), 32'(exp_stall));
            if (exp_req) begin
                chk("dmem_we", 32'(DMEM_WE), 32'(exp_we));
                chk("dmem_addr", DMEM_ADDR, exp_addr);
                chk("dmem_be", 32'(DMEM_BE), 32'(exp_be));
                if (exp_we) chk("dmem_wdata", DMEM_WDATA, exp_wdata);
            end
            if (chk_valid) chk("valid_out", 32'(VALID_OUT), 32'(exp_valid));
            chk("ctrl_wb_out", 32'(CTRL_WB_OUT), 32'(exp_ctrl));
            chk("misalign_out", 32'(MISALIGN_OUT), 32'(exp_mis));
            chk("buserr_out", 32'(BUSERR_OUT), 32'(exp_bus));
            if (chk_data) begin
                chk("aluresult_out", ALURESULT_OUT, exp_alu);
                chk("inst_out", INST_OUT, exp_inst);
            end
            if (chk_mem) chk("mem_out", MEM_OUT, exp_mem);
            if (STALL_OUT) stall_seen++;
            if (DMEM_REQ) begin
                cap_be    = DMEM_BE;
                cap_wdata = DMEM_WDATA;
            end
        end
    end

    // Reference behaviour from the lane rules, using plain arithmetic.
    function automatic void model(input logic [2:0] f3, input logic st,
                                  input logic [31:0] a, input logic [31:0] rs2,
                                  input logic [31:0] rd,
                                  output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] ld, output logic mis);
        int off   = int'(a[1:0]);
        int bytes = 1 << int'(f3[1:0]);
        logic [31:0] v;
        mis = (off % bytes) != 0;
        if (st) begin
            be = 4'(((1 << bytes) - 1) << off);
            if (bytes == 1)      wd = 32'(rs2[7:0]) * 32'h01010101;
            else if (bytes == 2) wd = 32'(rs2[15:0]) * 32'h00010001;
            else                 wd = rs2;
        end else begin
            be = 4'hF;
            wd = rs2;
        end
        v = rd >> (8 * off);
        if (bytes == 1) begin
            ld = v & 32'hFF;
            if (!f3[2] && v[7]) ld = ld | 32'hFFFFFF00;
        end else if (bytes == 2) begin
            ld = v & 32'hFFFF;
            if (!f3[2] && v[15]) ld = ld | 32'hFFFF0000;
        end else begin
            ld = rd;
        end
    endfunction

    task automatic set_reg_zero();
        exp_valid = 0; exp_ctrl = 0; exp_mis = 0; exp_bus = 0;
        exp_mem = 0; exp_alu = 0; exp_inst = 0;
        chk_valid = 1; chk_data = 1; chk_mem = 1;
    endtask

    // Drive one EX/MEM slot, answering the bus after rdy_at cycles.
    // Called at posedge+1; returns at posedge+1 after the result edge.
    task automatic run_op(input logic v, input logic [1:0] cm, input logic [1:0] cw,
                          input logic [31:0] a, input logic [31:0] rs2,
                          input logic [2:0] f3, input logic [31:0] rd,
                          input int rdy_at, input int lit_stall,
                          input logic lit_en, input logic [31:0] lit_mem);
        logic mem, st, ldop, mis;
        logic [3:0] be;
        logic [31:0] wd, ld, inst;
        int outcome;  // 0 pass, 1 misalign, 2 done, 3 buserr, 4 bubble
        mem  = v & (cm != 2'b00);
        st   = cm[0];
        ldop = cm[1] & ~cm[0];
        inst = {a[11:0], 5'd1, f3, 5'd2, 7'h03};
        model(f3, st, a, rs2, rd, be, wd, ld, mis);
        stall_seen = 0;
        for (int k = 0; k < 200; k++) begin
            VALID_IN = v; CTRL_MEM_IN = cm; CTRL_WB_IN = cw;
            ALURESULT_IN = a; WRITEDATA_IN = rs2; INST_IN = inst;
            DMEM_READY = (k == rdy_at); DMEM_RDATA = rd;
            exp_we = st; exp_addr = {a[31:2], 2'b00}; exp_be = be; exp_wdata = wd;
            if (!mem)              begin exp_req = 0; exp_stall = 0; outcome = 0; end
            else if (mis)          begin exp_req = 0; exp_stall = 0; outcome = 1; end
            else if (k == rdy_at)  begin exp_req = 1; exp_stall = 0; outcome = 2; end
            else if (k == TMO + 1) begin exp_req = 0; exp_stall = 0; outcome = 3; end
            else                   begin exp_req = 1; exp_stall = 1; outcome = 4; end
            @(posedge CLK); #1;
            exp_mis = 0; exp_bus = 0; chk_valid = 1; chk_data = 0; chk_mem = 0;
            exp_alu = a; exp_inst = inst; exp_mem = 0;
            case (outcome)
                0: begin exp_valid = v; exp_ctrl = cw; chk_data = 1; chk_mem = 1; end
                1: begin exp_valid = 1; exp_ctrl = 0; exp_mis = 1; chk_valid = 0; end
                2: begin exp_valid = 1; exp_ctrl = cw; chk_data = 1;
                         chk_mem = ldop; exp_mem = ld; end
                3: begin exp_valid = 1; exp_ctrl = 0; exp_bus = 1; end
                default: begin exp_valid = 0; exp_ctrl = 0; end
            endcase
            if (outcome != 4) break;
            if (k == 199) begin
                n_checks++; n_fail++;
                $display("FAIL op_bound: op at 0x%08h never completed", a);
            end
        end
        if (lit_stall >= 0) chk("stall_cycles", 32'(stall_seen), 32'(lit_stall));
        if (lit_en) chk("lit_mem_out", MEM_OUT, lit_mem);
    endtask

    initial begin
        RST = 1; VALID_IN = 0; CTRL_MEM_IN = 0; CTRL_WB_IN = 0;
        ALURESULT_IN = 0; WRITEDATA_IN = 0; INST_IN = 0;
        DMEM_READY = 0; DMEM_RDATA = 0;
        exp_req = 0; exp_stall = 0; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
        set_reg_zero();
        @(posedge CLK); #1;
        chk_en = 1;
        @(posedge CLK); #1;
        RST = 0;

        // non-memory op, and a load with VALID_IN=0
        run_op(1, 2'b00, 2'b10, 32'h12345678, 32'h0, 3'b000, 32'h0, 0, 0, 0, 0);
        run_op(0, 2'b10, 2'b11, 32'h00002000, 32'h0, 3'b010, 32'h0, 0, 0, 0, 0);
        // SB 0x1003, ready same cycle
        run_op(1, 2'b01, 2'b00, 32'h00001003, 32'h000000AB, 3'b000, 32'h0, 0, 0, 0, 0);
        chk("sb_be_lit", 32'(cap_be), 32'h8);
        chk("sb_wdata_lit", cap_wdata, 32'hABABABAB);
        // LB 0x2001, ready after 3 cycles
        run_op(1, 2'b10, 2'b11, 32'h00002001, 32'h0, 3'b000, 32'h0000F000, 3, 3, 1, 32'hFFFFFFF0);
        // LHU 0x2002
        run_op(1, 2'b10, 2'b11, 32'h00002002, 32'h0, 3'b101, 32'h80011234, 1, 1, 1, 32'h00008001);
        // LW 0x2002 misaligned
        run_op(1, 2'b10, 2'b11, 32'h00002002, 32'h0, 3'b010, 32'h0, 0, 0, 0, 0);
        chk("lw_misalign_lit", 32'(MISALIGN_OUT), 32'h1);
        // SH / SW / LH / LBU / misaligned SH / read+write treated as store
        run_op(1, 2'b01, 2'b00, 32'h00003002, 32'h1234BEEF, 3'b001, 32'h0, 2, 2, 0, 0);
        chk("sh_be_lit", 32'(cap_be), 32'hC);
        run_op(1, 2'b01, 2'b00, 32'h00004000, 32'hCAFEF00D, 3'b010, 32'h0, 0, 0, 0, 0);
        run_op(1, 2'b10, 2'b11, 32'h00002002, 32'h0, 3'b001, 32'h80010000, 0, 0, 1, 32'hFFFF8001);
        run_op(1, 2'b10, 2'b11, 32'h00002003, 32'h0, 3'b100, 32'h9F000000, 1, 1, 1, 32'h0000009F);
        run_op(1, 2'b01, 2'b00, 32'h00003001, 32'h00005555, 3'b001, 32'h0, 0, 0, 0, 0);
        run_op(1, 2'b11, 2'b10, 32'h00005001, 32'h00000077, 3'b000, 32'h0, 0, 0, 0, 0);
        chk("rw_store_be_lit", 32'(cap_be), 32'h2);
        // bus never answers: timeout
        run_op(1, 2'b10, 2'b11, 32'h00006000, 32'h0, 3'b010, 32'h0, NEVER, TMO + 1, 0, 0);
        chk("buserr_lit", 32'(BUSERR_OUT), 32'h1);
        run_op(1, 2'b00, 2'b10, 32'h0000ABCD, 32'h0, 3'b000, 32'h0, 0, 0, 0, 0);

        // reset in the second WAIT cycle, late READY afterwards
        VALID_IN = 1; CTRL_MEM_IN = 2'b10; CTRL_WB_IN = 2'b11;
        ALURESULT_IN = 32'h00007000; WRITEDATA_IN = 0; INST_IN = 32'h00002003;
        DMEM_READY = 0; DMEM_RDATA = 32'h11223344;
        exp_addr = 32'h00007000; exp_be = 4'hF; exp_we = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin RST = 1; exp_req = 0; exp_stall = 0; end
            else begin exp_req = 1; exp_stall = 1; end
            @(posedge CLK); #1;
            if (k < 2) begin exp_valid = 0; exp_ctrl = 0; exp_mis = 0; exp_bus = 0;
                             chk_data = 0; chk_mem = 0; chk_valid = 1; end
            else set_reg_zero();
        end
        RST = 0; VALID_IN = 0; CTRL_MEM_IN = 0; CTRL_WB_IN = 0;
        ALURESULT_IN = 0; INST_IN = 0; DMEM_READY = 1;
        exp_req = 0; exp_stall = 0;
        @(posedge CLK); #1;
        set_reg_zero();
        DMEM_READY = 0;
        @(posedge CLK); #1;
        chk("post_reset_valid", 32'(VALID_OUT), 32'h0);
        chk("post_reset_mem", MEM_OUT, 32'h0);

        run_op(1, 2'b00, 2'b01, 32'h00000042, 32'h0, 3'b000, 32'h0, 0, 0, 0, 0);
        @(negedge CLK);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_mem.md
RV32I_MEM -- requirements
Module: rv32i_mem

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the max WAIT cycles before a bus error is declared.
REQ-002 One clock; reset is synchronous and active-high; ports named CLK and RST.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 VALID_IN  in  1  EX/MEM slot holds a real instruction.
REQ-006 CTRL_MEM_IN  in  2  {memRead, memWrite}.
REQ-007 CTRL_WB_IN  in  2  {regwrite, memtoReg}, passed to WB.
REQ-008 ALURESULT_IN  in  32  effective address / ALU result.
REQ-009 WRITEDATA_IN  in  32  rs2 store data.
REQ-010 INST_IN  in  32  instruction; funct3 = INST_IN[14:12].
REQ-011 DMEM_REQ / DMEM_WE  out  1 / 1  bus request / write strobe.
REQ-012 DMEM_ADDR / DMEM_WDATA  out  32 / 32  word address ({addr[31:2],2'b00}) / lane-replicated store data.
REQ-013 DMEM_BE  out  4  byte enables.
REQ-014 DMEM_READY / DMEM_RDATA  in  1 / 32  bus completion / read word.
REQ-015 STALL_OUT  out  1  upstream must hold EX/MEM inputs.
REQ-016 VALID_OUT, CTRL_WB_OUT[1:0], MEM_OUT[31:0], ALURESULT_OUT[31:0], INST_OUT[31:0]  out  registered MEM/WB bundle.
REQ-017 MISALIGN_OUT / BUSERR_OUT  out  1 / 1  registered fault flags for the instruction in MEM/WB.

Function
REQ-018 FSM states IDLE, WAIT; IDLE on reset.
REQ-019 Memory op = VALID_IN & (memRead|memWrite); both set is treated as a store.
REQ-020 Store lanes: SB BE=4'b0001<<addr[1:0], WDATA={4{rs2[7:0]}}; SH BE=4'b0011<<{addr[1],1'b0}, WDATA={2{rs2[15:0]}}; SW BE=4'b1111; loads BE=4'b1111.
REQ-021 Load extraction: LB/LH sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0]; LW passes the word.
REQ-022 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no DMEM_REQ, registered next cycle with MISALIGN_OUT=1, CTRL_WB_OUT=2'b00.
REQ-023 IDLE + aligned memory op: DMEM_REQ=1 combinationally that cycle; address, data, BE and WE latched internally.
REQ-024 IDLE with DMEM_READY=1 in the same cycle: result registered at that edge, stay IDLE, zero stall.
REQ-025 IDLE with DMEM_READY=0: go to WAIT; DMEM_REQ and the latched bus fields held stable until READY.
REQ-026 STALL_OUT = DMEM_REQ & ~DMEM_READY, combinational.
REQ-027 WAIT + DMEM_READY: register result, return to IDLE at that edge.
REQ-028 While STALL_OUT=1 the MEM/WB register loads VALID_OUT=0 and CTRL_WB_OUT=2'b00 (bubble).
REQ-029 A 16-bit wait counter clears on entering WAIT and increments each WAIT cycle; at TIMEOUT_CYCLES without READY, register BUSERR_OUT=1, CTRL_WB_OUT=2'b00, VALID_OUT=1, and go to IDLE.
REQ-030 Non-memory or VALID_IN=0 ops register in one cycle: MEM_OUT=0, ALURESULT/INST/CTRL passed through, VALID_OUT=VALID_IN.
REQ-031 Fault flags are 0 whenever no fault occurs for the registered instruction.

Reset
REQ-032 RST forces IDLE, counter 0, DMEM_REQ/DMEM_WE/STALL_OUT 0, all MEM/WB outputs and fault flags 0.
REQ-033 RST in WAIT abandons the transaction; a late DMEM_READY after reset is ignored.

Structure
REQ-034 Shared package rv32i_pkg holds funct3 load/store encodings, FSM state enum, and the CTRL_MEM/CTRL_WB bit positions.
REQ-035 Sub-module rv32i_lsu_align (combinational) generates BE/WDATA, load extraction, and the misalign check.

Verification
REQ-036 SB addr 0x1003, rs2=0x000000AB, READY same cycle -> BE=4'b1000, WDATA=0xABABABAB, STALL_OUT=0 throughout.
REQ-037 LB addr 0x2001, RDATA=0x0000F000, READY after 3 cycles -> STALL_OUT high exactly 3 cycles, 3 bubbles, then MEM_OUT=0xFFFFFFF0.
REQ-038 LHU addr 0x2002, RDATA=0x8001xxxx -> MEM_OUT=0x00008001.
REQ-039 LW addr 0x2002 -> no DMEM_REQ, MISALIGN_OUT=1, CTRL_WB_OUT=00 next cycle.
REQ-040 TIMEOUT_CYCLES=4, READY never -> BUSERR_OUT=1 after 4 WAIT cycles, FSM back to IDLE.
REQ-041 RST asserted in 2nd WAIT cycle, READY the cycle after -> all outputs 0, no result registered.
